uart_rx: RTL

- Serial UART receiver, 8N1 frame, LSB first, fixed baud of CLKS_PER_BIT system clocks per bit.
- Receive-side counterpart of the team's UART transmitter; the two share the CLKS_PER_BIT convention.
- Synchronises the asynchronous serial line, validates the start bit at mid-bit, samples each data bit at mid-bit and checks the stop bit.
- Presents each received byte with a one-cycle data-valid pulse to downstream logic (LED/7-seg display, loopback to the transmitter).

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver.
//   - rx_state_t : FSM state encoding (IDLE=0 .. PARITY=5, 3 bits), common
//                  with the transmitter.
//   - DEFAULT_CLKS_PER_BIT : 25 MHz / 115200 baud.
//   - parity_ok() : even-parity check over data byte plus parity bit.
package uart_rx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 217;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4,
        S_PARITY  = 3'd5
    } rx_state_t;

    // Even parity: the XOR of all eight data bits and the parity bit is 0.
    function automatic logic parity_ok(input logic [7:0] data, input logic parity_bit);
        return ((^data) ^ parity_bit) == 1'b0;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
// Ports:
//   clk_i   in  system clock
//   rst_i   in  synchronous active-high reset (both flops reset to 1 = idle line)
//   async_i in  asynchronous input
//   sync_o  out synchronised copy, two clocks behind async_i
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta   <= 1'b1;
            sync_o <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make these two distinct flops;
            // blocking ones would collapse the chain into a single stage.
            meta   <= async_i;
            sync_o <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, CLKS_PER_BIT clocks per bit.
// Optional 8E1 parity checking is built when UART_RX_PARITY_EN is defined.
// Ports:
//   clk_i        in   system clock
//   rst_i        in   synchronous active-high reset
//   rx_serial_i  in   asynchronous serial line, idles high
//   rx_dv_o      out  one-cycle pulse: rx_byte_o holds a new good byte
//   rx_byte_o    out  last good byte, held until the next good frame
//   rx_active_o  out  high from START through STOP
//   frame_err_o  out  one-cycle pulse: stop bit sampled low
//   parity_err_o out  one-cycle pulse: parity mismatch (0 without the feature)
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_serial_i,
    output logic       rx_dv_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_active_o,
    output logic       frame_err_o,
    output logic       parity_err_o
);

    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

    logic             rx_sync;
    rx_state_t        state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    // Cleared by a framing error; a low line only starts a new frame once
    // it has been seen high again, so a break does not retrigger forever.
    logic             armed;

    uart_rx_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (rx_serial_i),
        .sync_o  (rx_sync)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    logic parity_err_q;
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            armed       <= 1'b1;
            rx_dv_o     <= 1'b0;
            rx_byte_o   <= '0;
            rx_active_o <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Status pulses default low; only the STOP decision raises one.
            rx_dv_o     <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    rx_active_o <= 1'b0;
                    if (rx_sync) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state       <= S_START;
                        rx_active_o <= 1'b1;
                    end
                end

                // Re-check the line at the start-bit mid-point to reject glitches.
                S_START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        if (!rx_sync) begin
                            state <= S_DATA;
                        end else begin
                            state       <= S_IDLE;
                            rx_active_o <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // Counting a full bit from the start mid-point lands on each data mid-point.
                S_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_sync;
                        bit_idx            <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt    <= '0;
                        parity_bit <= rx_sync;
                        state      <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif

                // A bad stop bit outranks a parity mismatch.
                S_STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt     <= '0;
                        rx_active_o <= 1'b0;
                        state       <= S_CLEANUP;
                        if (!rx_sync) begin
                            frame_err_o <= 1'b1;
                            armed       <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        end else if (!parity_ok(shift_reg, parity_bit)) begin
                            parity_err_q <= 1'b1;
`endif
                        end else begin
                            rx_dv_o   <= 1'b1;
                            rx_byte_o <= shift_reg;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // One cycle for the status pulse to drop before listening again.
                S_CLEANUP: begin
                    clk_cnt <= '0;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
